cs_trgt_fringe_mux: RTL

//  Target-side fringe controller, generalised to NUM_CH mission-clock channels.
//  Per mission-clock event it freezes that clock, uploads a sampled SUT vector to the initiator,

---
 rtl/cs_fringe_pkg.sv | 24 ++
 rtl/cs_rr_arb.sv | 36 +++
 rtl/cs_trgt_fringe_mux.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cs_fringe_pkg.sv
// Shared types and helpers for the cs fringe controllers (target and initiator side).
package cs_fringe_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PUT,
    GET,
    WAIT
  } fringe_state_e;

  // Default watchdog budget, in utility-clock cycles, for a download to arrive.
  localparam int unsigned WDOG_DEFAULT = 10000;

  // Channel index width; at least one bit even for a single channel.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a fringe vector: {wen/valid, data}.
  function automatic int unsigned vec_w(input int unsigned dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/cs_rr_arb.sv
// Round-robin picker: first requester at or after ptr, as a one-hot grant and an index.
module cs_rr_arb
  import cs_fringe_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]       req,
  input  logic [ch_w(NUM_CH)-1:0] ptr,
  output logic [NUM_CH-1:0]       gnt_c,
  output logic [ch_w(NUM_CH)-1:0] idx_c
);

  localparam int unsigned CHW = ch_w(NUM_CH);

  int unsigned pos;
  logic        hit;

  // Scan requesters starting at ptr and wrapping; the first one found wins.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    hit   = 1'b0;
    pos   = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pos = (32'(ptr) + i) % NUM_CH;
      if (!hit && req[CHW'(pos)]) begin
        hit   = 1'b1;
        idx_c = CHW'(pos);
      end
    end
    if (hit) begin
      gnt_c[idx_c] = 1'b1;
    end
  end

endmodule

// File: rtl/cs_trgt_fringe_mux.sv
// Target-side fringe controller: freezes a mission clock per event, uploads the
// sampled SUT vector, waits for the download, drives it to the SUT and releases the clock.
module cs_trgt_fringe_mux
  import cs_fringe_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DW       = 8,
  parameter int unsigned WDOG_MAX = WDOG_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_CH-1:0]        evt_i,
  input  logic [NUM_CH-1:0]        ch_en_i,
  input  logic                     ul_valid_i,
  input  logic [DW-1:0]            ul_data_i,
  output logic [NUM_CH-1:0]        freeze_clk_o,
  output logic [NUM_CH-1:0]        dl_wen_o,
  output logic [NUM_CH*DW-1:0]     dl_data_o,
  output logic                     put_req_o,
  output logic [ch_w(NUM_CH)-1:0]  put_ch_o,
  output logic [DW:0]              put_data_o,
  input  logic                     put_ack_i,
  output logic                     get_req_o,
  output logic [ch_w(NUM_CH)-1:0]  get_ch_o,
  input  logic                     get_vld_i,
  input  logic [DW:0]              get_data_i,
  output logic [NUM_CH-1:0]        err_timeout_o,
  output logic [NUM_CH-1:0]        err_overrun_o,
  output logic                     busy_o
);

  localparam int unsigned CHW = ch_w(NUM_CH);
  localparam int unsigned VW  = vec_w(DW);
  localparam int unsigned WDW = $clog2(WDOG_MAX + 1);

  fringe_state_e     state;
  logic [CHW-1:0]    cur_ch;
  logic [CHW-1:0]    rr_ptr;
  logic [CHW-1:0]    nxt_ptr_c;
  logic [NUM_CH-1:0] pending;
  logic [VW-1:0]     snap [NUM_CH];
  logic [WDW-1:0]    wdog;
  logic [NUM_CH-1:0] arb_gnt_c;
  logic [CHW-1:0]    arb_idx_c;

  cs_rr_arb #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req   (pending),
    .ptr   (rr_ptr),
    .gnt_c (arb_gnt_c),
    .idx_c (arb_idx_c)
  );

  // Round-robin pointer moves to the channel after the one just served.
  assign nxt_ptr_c = (32'(cur_ch) == NUM_CH - 1) ? '0 : cur_ch + 1'b1;

  // Busy while a transaction is in flight or any channel still waits for service.
  assign busy_o = (state != IDLE) || (|pending);

  // Service FSM plus per-channel event capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      cur_ch        <= '0;
      rr_ptr        <= '0;
      pending       <= '0;
      wdog          <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        snap[k] <= '0;
      end
      freeze_clk_o  <= '0;
      dl_wen_o      <= '0;
      dl_data_o     <= '0;
      put_req_o     <= 1'b0;
      put_ch_o      <= '0;
      put_data_o    <= '0;
      get_req_o     <= 1'b0;
      get_ch_o      <= '0;
      err_timeout_o <= '0;
      err_overrun_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|arb_gnt_c) begin
            state      <= PUT;
            cur_ch     <= arb_idx_c;
            put_req_o  <= 1'b1;
            put_ch_o   <= arb_idx_c;
            put_data_o <= snap[arb_idx_c];
          end
        end
        PUT: begin
          // Download request is raised on the ack edge; vld is only looked at from WAIT on.
          if (put_ack_i) begin
            put_req_o <= 1'b0;
            get_req_o <= 1'b1;
            get_ch_o  <= cur_ch;
            wdog      <= '0;
            state     <= WAIT;
          end
        end
        GET: begin
          get_req_o <= 1'b1;
          get_ch_o  <= cur_ch;
          wdog      <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (get_vld_i) begin
            get_req_o                          <= 1'b0;
            dl_wen_o[cur_ch]                   <= get_data_i[DW];
            dl_data_o[int'(cur_ch)*DW +: DW]   <= get_data_i[DW-1:0];
            pending[cur_ch]                    <= 1'b0;
            freeze_clk_o[cur_ch]               <= 1'b0;
            rr_ptr                             <= nxt_ptr_c;
            state                              <= IDLE;
          end else if (wdog == WDW'(WDOG_MAX - 1)) begin
            get_req_o             <= 1'b0;
            err_timeout_o[cur_ch] <= 1'b1;
            pending[cur_ch]       <= 1'b0;
            freeze_clk_o[cur_ch]  <= 1'b0;
            rr_ptr                <= nxt_ptr_c;
            state                 <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Capture events; a repeat on a still-pending channel only flags overrun.
      for (int k = 0; k < NUM_CH; k++) begin
        if (evt_i[k] && ch_en_i[k]) begin
          if (pending[k]) begin
            err_overrun_o[k] <= 1'b1;
          end else begin
            pending[k]      <= 1'b1;
            freeze_clk_o[k] <= 1'b1;
            snap[k]         <= {ul_valid_i, ul_data_i};
          end
        end
      end
    end
  end

endmodule
